// File: rtl/iter_alu_if.sv
// Request/response bundle between the operand-select stage and the iterative ALU.
// The master side issues ALU ops and takes results; the slave side is the execution unit.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             illegal;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: logic/arith/compare ops finish in one cycle, shifts iterate
// one bit per cycle. Results are held until the consumer takes them.
module iter_alu #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  iter_alu_if.slave  bus
);
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLT    = 4'h5;
  localparam logic [3:0] ALU_SLTU   = 4'h6;
  localparam logic [3:0] ALU_SLL    = 4'h7;
  localparam logic [3:0] ALU_SRL    = 4'h8;
  localparam logic [3:0] ALU_SRA    = 4'h9;
  localparam logic [3:0] ALU_COPY_B = 4'hA;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SH_L = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shift_t;

  state_t             state_reg, state_next;
  shift_t             kind_reg, kind_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               illegal_reg, illegal_next;
  logic [SHAMT_W-1:0] count_reg, count_next;

  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic [WIDTH-1:0]   alu_value;
  logic               alu_illegal;
  logic               is_shift;
  shift_t             shift_kind;
  logic [WIDTH-1:0]   shifted;

  assign shamt  = bus.b[SHAMT_W-1:0];
  assign accept = bus.in_valid && (state_reg == IDLE);

  // Single-cycle datapath and shift-op decode, evaluated on the live inputs at accept.
  always_comb begin
    alu_value   = '0;
    alu_illegal = 1'b0;
    is_shift    = 1'b0;
    shift_kind  = SH_L;
    case (bus.alu_op)
      ALU_ADD:    alu_value = bus.a + bus.b;
      ALU_SUB:    alu_value = bus.a - bus.b;
      ALU_AND:    alu_value = bus.a & bus.b;
      ALU_OR:     alu_value = bus.a | bus.b;
      ALU_XOR:    alu_value = bus.a ^ bus.b;
      ALU_SLT:    alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLTU:   alu_value = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      ALU_COPY_B: alu_value = bus.b;
      ALU_SLL: begin
        is_shift   = 1'b1;
        shift_kind = SH_L;
      end
      ALU_SRL: begin
        is_shift   = 1'b1;
        shift_kind = SH_RL;
      end
      ALU_SRA: begin
        is_shift   = 1'b1;
        shift_kind = SH_RA;
      end
      default:    alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    shifted = result_reg;
    case (kind_reg)
      SH_L:    shifted = {result_reg[WIDTH-2:0], 1'b0};
      SH_RL:   shifted = {1'b0, result_reg[WIDTH-1:1]};
      SH_RA:   shifted = {result_reg[WIDTH-1], result_reg[WIDTH-1:1]};
      default: shifted = result_reg;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    kind_next    = kind_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
    count_next   = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_shift) begin
            result_next  = bus.a;
            illegal_next = 1'b0;
            count_next   = shamt;
            kind_next    = shift_kind;
            state_next   = (shamt == '0) ? DONE : SHIFT;
          end else begin
            result_next  = alu_value;
            illegal_next = alu_illegal;
            state_next   = DONE;
          end
        end
      end
      SHIFT: begin
        result_next = shifted;
        count_next  = count_reg - 1'b1;
        // The shift that consumes the last count lands the result in DONE.
        if (count_reg == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      kind_reg    <= SH_L;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      kind_reg    <= kind_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
      count_reg   <= count_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.illegal   = illegal_reg;
endmodule
